// File: rtl/e_mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings, FSM states
// and small op-class helpers used by the controller and the arithmetic block.
package e_mdu_ctrl_pkg;

  localparam int unsigned OpW = 3;

  typedef logic [OpW-1:0] md_op_t;

  localparam md_op_t MdMult  = 3'd0;
  localparam md_op_t MdMultu = 3'd1;
  localparam md_op_t MdDiv   = 3'd2;
  localparam md_op_t MdDivu  = 3'd3;
  localparam md_op_t MdMthi  = 3'd4;
  localparam md_op_t MdMtlo  = 3'd5;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  function automatic logic is_mul(input md_op_t op);
    return (op == MdMult) || (op == MdMultu);
  endfunction

  function automatic logic is_div(input md_op_t op);
    return (op == MdDiv) || (op == MdDivu);
  endfunction

  function automatic logic is_muldiv(input md_op_t op);
    return is_mul(op) || is_div(op);
  endfunction

  function automatic logic is_signed_op(input md_op_t op);
    return (op == MdMult) || (op == MdDiv);
  endfunction

endpackage

// File: rtl/e_mdu_ctrl_if.sv
// E-stage <-> MDU signal bundle: issue side driven by the pipeline, HI/LO/busy/stall
// returned by the controller.
interface e_mdu_ctrl_if;
  import e_mdu_ctrl_pkg::*;

  logic        start;
  md_op_t      md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        stall_md;

  modport master (
    output start, md_op, a, b, d_is_md,
    input  busy, hi, lo, done, stall_md
  );

  modport slave (
    input  start, md_op, a, b, d_is_md,
    output busy, hi, lo, done, stall_md
  );

endinterface

// File: rtl/e_mdu_arith.sv
// Purely combinational MDU datapath: 64-bit signed/unsigned product and
// truncating quotient/remainder, packed as {hi, lo}.
module e_mdu_arith
  import e_mdu_ctrl_pkg::*;
(
  input  md_op_t      op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o,
  output logic        div0_o
);

  logic        sgn;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quot;
  logic [31:0] rem;

  assign sgn = is_signed_op(op_i);

  // Low 64 bits of the product of sign/zero-extended operands is the exact result.
  assign ext_a   = sgn ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
  assign ext_b   = sgn ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
  assign product = ext_a * ext_b;

  assign neg_a = sgn & a_i[31];
  assign neg_b = sgn & b_i[31];
  assign mag_a = neg_a ? (~a_i + 32'd1) : a_i;
  assign mag_b = neg_b ? (~b_i + 32'd1) : b_i;

  assign div0_o  = is_div(op_i) && (b_i == 32'd0);
  // Divisor forced non-zero so the divider never sees 0; the result is discarded anyway.
  assign divisor = (b_i == 32'd0) ? 32'd1 : mag_b;

  assign uq = mag_a / divisor;
  assign ur = mag_a % divisor;

  // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negates to itself.
  assign quot = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
  assign rem  = neg_a ? (~ur + 32'd1) : ur;

  always_comb begin
    result_o = 64'd0;
    if (is_mul(op_i)) begin
      result_o = product;
    end else if (is_div(op_i)) begin
      result_o = {rem, quot};
    end
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide controller: owns HI/LO, sequences multi-cycle MULT/DIV with a
// down-counter, executes MTHI/MTLO in one edge, and raises the D-stage MD stall.
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int unsigned MultCyc = 5,
  parameter int unsigned DivCyc  = 10,
  parameter int unsigned CntW    = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  e_mdu_ctrl_if.slave  md_if
);

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     pend_hi_q, pend_hi_d;
  logic [31:0]     pend_lo_q, pend_lo_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            done_q, done_d;

  logic [63:0]     arith_res;
  logic            div0;
  logic            busy;
  logic            start_muldiv;

  e_mdu_arith u_arith (
    .op_i     (md_if.md_op),
    .a_i      (md_if.a),
    .b_i      (md_if.b),
    .result_o (arith_res),
    .div0_o   (div0)
  );

  assign busy         = (state_q == StBusy);
  assign start_muldiv = md_if.start && is_muldiv(md_if.md_op);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_muldiv) begin
          state_d = StBusy;
          cnt_d   = is_div(md_if.md_op) ? CntW'(DivCyc - 1) : CntW'(MultCyc - 1);
          // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
          if (div0) begin
            pend_hi_d = hi_q;
            pend_lo_d = lo_q;
          end else begin
            pend_hi_d = arith_res[63:32];
            pend_lo_d = arith_res[31:0];
          end
        end else if (md_if.start && (md_if.md_op == MdMthi)) begin
          hi_d = md_if.a;
        end else if (md_if.start && (md_if.md_op == MdMtlo)) begin
          lo_d = md_if.a;
        end
      end
      StBusy: begin
        // A start here is illegal (D is stalled) and deliberately ignored.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign md_if.busy     = busy;
  assign md_if.hi       = hi_q;
  assign md_if.lo       = lo_q;
  assign md_if.done     = done_q;
  // MFHI/MFLO in D also stall, so they never read HI/LO before the commit.
  assign md_if.stall_md = md_if.d_is_md && (busy || start_muldiv);

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Scoreboard bench for e_mdu_ctrl: stimulus pushes expected HI/LO per mult/div,
// a monitor pops and compares on every done pulse.
module tb_e_mdu_ctrl;
  import e_mdu_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  e_mdu_ctrl_if u_if ();

  e_mdu_ctrl u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .md_if  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] sb_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic tb_is_md(input logic [2:0] op);
    return op <= 3'd3;
  endfunction

  // Architectural reference: what {HI,LO} must hold after the op.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] cur_hi,
                                             input logic [31:0] cur_lo);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return {cur_hi, cur_lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {cur_hi, cur_lo};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [63:0] exp;
    if (rst_n && u_if.done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got done=1, expected no commit at %0t", $time);
      end else begin
        exp = sb_q.pop_front();
        chk("commit_hi", {32'd0, u_if.hi}, {32'd0, exp[63:32]});
        chk("commit_lo", {32'd0, u_if.lo}, {32'd0, exp[31:0]});
      end
    end
  end

  // Drive one op now (away from posedge); returns at the negedge after the issue edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic dmd);
    logic [63:0] exp;
    u_if.start   = 1'b1;
    u_if.md_op   = op;
    u_if.a       = a;
    u_if.b       = b;
    u_if.d_is_md = dmd;
    #1;
    chk("stall_issue", {63'd0, u_if.stall_md}, {63'd0, dmd & tb_is_md(op)});
    if (tb_is_md(op)) begin
      exp = ref_result(op, a, b, m_hi, m_lo);
      sb_q.push_back(exp);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end else if (op == 3'd4) begin
      m_hi = a;
    end else if (op == 3'd5) begin
      m_lo = a;
    end
    @(posedge clk);
    @(negedge clk);
    u_if.start = 1'b0;
  endtask

  // Called right after issue() of a mult/div; ends in the cycle busy falls.
  task automatic wait_busy(input int n, input logic dmd);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("busy_high", {63'd0, u_if.busy}, 64'd1);
      chk("stall_busy", {63'd0, u_if.stall_md}, {63'd0, dmd});
      chk("done_early", {63'd0, u_if.done}, 64'd0);
      if (i < n - 1) @(negedge clk);
    end
    @(negedge clk);
    #1;
    chk("busy_fall", {63'd0, u_if.busy}, 64'd0);
    chk("stall_fall", {63'd0, u_if.stall_md}, 64'd0);
    chk("done_pulse", {63'd0, u_if.done}, 64'd1);
  endtask

  task automatic check_mt();
    #1;
    chk("mt_hi", {32'd0, u_if.hi}, {32'd0, m_hi});
    chk("mt_lo", {32'd0, u_if.lo}, {32'd0, m_lo});
    chk("mt_busy", {63'd0, u_if.busy}, 64'd0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd);
    issue(op, a, b, dmd);
    if (tb_is_md(op)) wait_busy((op >= 3'd2) ? 10 : 5, dmd);
    else check_mt();
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] ra, rb;
    checks = 0;
    errors = 0;
    m_hi = '0;
    m_lo = '0;
    rst_n = 1'b0;
    u_if.start = 1'b0;
    u_if.md_op = 3'd0;
    u_if.a = '0;
    u_if.b = '0;
    u_if.d_is_md = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {63'd0, u_if.busy}, 64'd0);
    chk("rst_done", {63'd0, u_if.done}, 64'd0);
    chk("rst_hilo", {u_if.hi, u_if.lo}, 64'd0);
    chk("rst_stall", {63'd0, u_if.stall_md}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
    run_op(3'd3, 32'd77, 32'd0, 1'b1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op(3'd2, 32'd0, 32'd0, 1'b1);

    // Reset in the third busy cycle of a DIV.
    issue(3'd2, 32'd100, 32'd3, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, u_if.busy}, 64'd0);
    chk("arst_hilo", {u_if.hi, u_if.lo}, 64'd0);
    sb_q.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      #1;
      chk("arst_idle_busy", {63'd0, u_if.busy}, 64'd0);
      chk("arst_no_done", {63'd0, u_if.done}, 64'd0);
    end

    // Back-to-back: MTLO, MULTU, then a new op in the cycle busy falls.
    run_op(3'd5, 32'h0000_000A, 32'd0, 1'b1);
    run_op(3'd1, 32'd3, 32'd4, 1'b1);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 9));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op(op, ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        #1;
        chk("idle_hi", {32'd0, u_if.hi}, {32'd0, m_hi});
        chk("idle_lo", {32'd0, u_if.lo}, {32'd0, m_lo});
        chk("idle_stall", {63'd0, u_if.stall_md}, 64'd0);
      end
    end

    @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
